// File: rtl/ram_bridge_pkg.sv
// ram_bridge shared types and defaults.
// 64-bit CPU bus to 32-bit synchronous SRAM bridge.
package ram_bridge_pkg;

  localparam int MEM_AW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    RD_CAP,
    WR_LO,
    WR_HI,
    DONE,
    HOLD
  } state_e;

endpackage

// File: rtl/ram_bridge_if.sv
// ram_bridge bus bundle: CPU strobes on one side, SRAM port on the other.
// slave is the bridge view, master is the CPU/SRAM environment view.
import ram_bridge_pkg::*;

interface ram_bridge_if #(
  parameter int MEM_AW = MEM_AW_DEF
);
  logic              ram_cs;
  logic              ram_we;
  logic              ram_oe;
  logic [63:0]       bus_addr;
  logic [63:0]       bus_wdata;
  logic [63:0]       bus_rdata;
  logic              bus_ready;
  logic              bus_err;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  ram_cs, ram_we, ram_oe,
    input  bus_addr, bus_wdata,
    output bus_rdata, bus_ready, bus_err,
    output mem_en, mem_we,
    output mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output ram_cs, ram_we, ram_oe,
    output bus_addr, bus_wdata,
    input  bus_rdata, bus_ready, bus_err,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ram_bridge.sv
// Splits each 64-bit CPU access into two 32-bit SRAM beats.
// Strobes held after completion park the FSM in HOLD until ram_cs drops.
import ram_bridge_pkg::*;

module ram_bridge #(
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  ram_bridge_if.slave bus
);

  localparam int IW = MEM_AW - 1;

  state_e        state;
  state_e        state_nx;
  logic [IW-1:0] idx_q;
  logic [63:0]   wdata_q;
  logic [31:0]   lo_q;
  logic          err_q;
  logic          err_nx;
  logic          req;
  logic          bad;
  logic          en;
  logic          we;
  logic          hi;

  always_comb begin
    req = bus.ram_cs & (bus.ram_we ^ bus.ram_oe);
    bad = bus.ram_cs & bus.ram_we & bus.ram_oe;
    if (req) begin
      bad = (|bus.bus_addr[2:0]) |
            (|bus.bus_addr[63:MEM_AW+2]);
    end
  end

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bad) begin
          state_nx = HOLD;
          err_nx   = 1'b1;
        end else if (req) begin
          state_nx = bus.ram_we ? WR_LO : RD_LO;
        end
      end
      RD_LO:   state_nx = RD_HI;
      RD_HI:   state_nx = RD_CAP;
      RD_CAP:  state_nx = DONE;
      WR_LO:   state_nx = WR_HI;
      WR_HI:   state_nx = DONE;
      DONE:    state_nx = HOLD;
      HOLD: begin
        if (!bus.ram_cs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      err_q         <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      lo_q          <= '0;
      bus.bus_rdata <= '0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      if (state == IDLE && req && !bad) begin
        idx_q   <= bus.bus_addr[MEM_AW+1:3];
        wdata_q <= bus.bus_wdata;
      end
      if (state == RD_HI) lo_q <= bus.mem_rdata;
      // high word arrives one cycle after the RD_HI beat
      if (state == RD_CAP) begin
        bus.bus_rdata <= {bus.mem_rdata, lo_q};
      end
    end
  end

  always_comb begin
    en = (state == RD_LO) | (state == RD_HI) |
         (state == WR_LO) | (state == WR_HI);
    we = (state == WR_LO) | (state == WR_HI);
    hi = (state == RD_HI) | (state == WR_HI);
  end

  assign bus.bus_ready = (state == DONE);
  assign bus.bus_err   = err_q;
  assign bus.mem_en    = en;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = en ? {idx_q, hi} : '0;
  assign bus.mem_wdata = !we ? '0 :
                         hi  ? wdata_q[63:32] :
                               wdata_q[31:0];

endmodule

// File: tb/tb_ram_bridge.sv
// Directed bench for ram_bridge with a one-cycle-latency SRAM model.
// Completions are checked against a scoreboard queue of expected results.
module tb_ram_bridge;

  typedef struct {
    logic        rd;
    logic [63:0] data;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   en_cnt;
  int   rdy_cnt;
  int   err_cnt;
  exp_t sb[$];

  logic        pre_en;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;
  logic [31:0] sram [256];
  logic [31:0] sram_q;

  ram_bridge_if #(.MEM_AW(16)) mif ();

  ram_bridge #(.MEM_AW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sram_sync: synchronous SRAM, read data one cycle after the access
  always @(posedge clk) begin
    if (pre_en) begin
      sram[pre_a] <= pre_d;
    end else if (mif.mem_en) begin
      if (mif.mem_we) sram[mif.mem_addr[7:0]] <= mif.mem_wdata;
      sram_q <= sram[mif.mem_addr[7:0]];
    end
  end
  assign mif.mem_rdata = sram_q;

  always @(posedge clk) begin
    if (mif.mem_en)    en_cnt  <= en_cnt + 1;
    if (mif.bus_ready) rdy_cnt <= rdy_cnt + 1;
    if (mif.bus_err)   err_cnt <= err_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_en = 1'b1;
    pre_a  = a;
    pre_d  = d;
    step(1);
    pre_en = 1'b0;
  endtask

  task automatic strobe(input logic cs, input logic we, input logic oe);
    mif.ram_cs = cs;
    mif.ram_we = we;
    mif.ram_oe = oe;
  endtask

  task automatic access(input string tag,
                        input logic rd,
                        input logic [63:0] addr,
                        input logic [63:0] wd,
                        input logic [63:0] exp_d,
                        input int hold);
    exp_t e;
    int   cyc;
    sb.push_back('{rd, exp_d, rd ? 4 : 3});
    strobe(1'b1, !rd, rd);
    mif.bus_addr  = addr;
    mif.bus_wdata = wd;
    step(1);
    if (hold == 0) strobe(1'b0, 1'b0, 1'b0);
    mif.bus_addr  = 64'hDEAD_BEEF_0000_0008;
    mif.bus_wdata = 64'h5555_AAAA_5555_AAAA;
    cyc = 1;
    while (!mif.bus_ready && cyc < 12) begin
      step(1);
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, "_ready"}, 64'(mif.bus_ready), 64'd1);
    chk({tag, "_lat"}, 64'(cyc), 64'(e.lat));
    if (e.rd) chk({tag, "_rdata"}, mif.bus_rdata, e.data);
    step(1);
    chk({tag, "_pulse"}, 64'(mif.bus_ready), 64'd0);
    if (hold != 0) begin
      step(hold);
      strobe(1'b0, 1'b0, 1'b0);
    end
    step(2);
  endtask

  task automatic bad_req(input string tag,
                         input logic we, input logic oe,
                         input logic [63:0] addr);
    int e0;
    int r0;
    int x0;
    e0 = en_cnt;
    r0 = rdy_cnt;
    x0 = err_cnt;
    strobe(1'b1, we, oe);
    mif.bus_addr = addr;
    step(1);
    chk({tag, "_err"}, 64'(mif.bus_err), 64'd1);
    strobe(1'b0, 1'b0, 1'b0);
    step(1);
    chk({tag, "_err_end"}, 64'(mif.bus_err), 64'd0);
    step(2);
    chk({tag, "_err_cnt"}, 64'(err_cnt - x0), 64'd1);
    chk({tag, "_no_mem"}, 64'(en_cnt - e0), 64'd0);
    chk({tag, "_no_rdy"}, 64'(rdy_cnt - r0), 64'd0);
  endtask

  initial begin
    int e0;
    int r0;
    n_chk   = 0;
    n_fail  = 0;
    en_cnt  = 0;
    rdy_cnt = 0;
    err_cnt = 0;
    pre_en  = 1'b0;
    pre_a   = '0;
    pre_d   = '0;
    reset   = 1'b0;
    strobe(1'b0, 1'b0, 1'b0);
    mif.bus_addr  = '0;
    mif.bus_wdata = '0;
    #1;
    chk("rst_ready", 64'(mif.bus_ready), 64'd0);
    chk("rst_err", 64'(mif.bus_err), 64'd0);
    chk("rst_mem_en", 64'(mif.mem_en), 64'd0);
    chk("rst_rdata", mif.bus_rdata, 64'd0);
    preload(8'd4, 32'h1122_3344);
    preload(8'd5, 32'hAABB_CCDD);
    preload(8'd6, 32'h0);
    preload(8'd7, 32'h0);
    reset = 1'b1;
    step(1);

    access("rd10", 1'b1, 64'h10, 64'h0,
           64'hAABB_CCDD_1122_3344, 0);
    access("wr18", 1'b0, 64'h18, 64'h0123_4567_89AB_CDEF,
           64'h0, 0);
    chk("wr_w6", 64'(sram[6]), 64'h89AB_CDEF);
    chk("wr_w7", 64'(sram[7]), 64'h0123_4567);
    chk("rdata_kept", mif.bus_rdata, 64'hAABB_CCDD_1122_3344);
    access("rd18", 1'b1, 64'h18, 64'h0,
           64'h0123_4567_89AB_CDEF, 0);

    bad_req("misalign", 1'b0, 1'b1, 64'h14);
    bad_req("both", 1'b1, 1'b1, 64'h10);
    bad_req("range", 1'b0, 1'b1, 64'h40000);

    e0 = en_cnt;
    r0 = rdy_cnt;
    access("held", 1'b1, 64'h10, 64'h0,
           64'hAABB_CCDD_1122_3344, 10);
    chk("held_mem", 64'(en_cnt - e0), 64'd2);
    chk("held_rdy", 64'(rdy_cnt - r0), 64'd1);

    r0 = rdy_cnt;
    strobe(1'b1, 1'b1, 1'b0);
    mif.bus_addr  = 64'h18;
    mif.bus_wdata = 64'hFEED_FACE_CAFE_BABE;
    step(1);
    strobe(1'b0, 1'b0, 1'b0);
    step(1);
    chk("wrhi_we", 64'(mif.mem_we), 64'd1);
    chk("wrhi_addr", 64'(mif.mem_addr), 64'd7);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_en", 64'(mif.mem_en), 64'd0);
    chk("mid_rst_we", 64'(mif.mem_we), 64'd0);
    chk("mid_rst_addr", 64'(mif.mem_addr), 64'd0);
    chk("mid_rst_wd", 64'(mif.mem_wdata), 64'd0);
    chk("mid_rst_rdata", mif.bus_rdata, 64'd0);
    chk("mid_rst_rdy", 64'(mif.bus_ready), 64'd0);
    step(3);
    chk("mid_rst_w7", 64'(sram[7]), 64'h0123_4567);
    chk("mid_rst_w6", 64'(sram[6]), 64'hCAFE_BABE);
    chk("mid_rst_nordy", 64'(rdy_cnt - r0), 64'd0);
    reset = 1'b1;
    access("post_rst", 1'b1, 64'h18, 64'h0,
           64'h0123_4567_CAFE_BABE, 0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bridge.md
RAM_BRIDGE -- requirements
Module: ram_bridge

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports ram_cs, ram_we and ram_oe, each input, 1, the CPU bus strobes: chip select, write request and read request.
REQ-004 SHALL have port bus_addr, input, 64, CPU byte address.
REQ-005 SHALL have port bus_wdata, input, 64, CPU store data.
REQ-006 SHALL have port bus_rdata, output, 64, load/fetch data, valid while bus_ready=1.
REQ-007 SHALL have port bus_ready, output, 1, one-cycle completion pulse.
REQ-008 SHALL have port bus_err, output, 1, one-cycle error pulse instead of bus_ready.
REQ-009 SHALL have ports mem_en, output, 1, and mem_we, output, 1, the SRAM access enable and write enable.
REQ-010 SHALL have port mem_addr, output, 16, SRAM 32-bit word address.
REQ-011 SHALL have port mem_wdata, output, 32, SRAM write data.
REQ-012 SHALL have port mem_rdata, input, 32, SRAM read data, valid one cycle after a read access (mem_en=1, mem_we=0).
REQ-013 SHALL use parameter MEM_AW, default 16, as the SRAM word-address width.

Function
REQ-014 SHALL accept a request in IDLE when ram_cs=1 and exactly one of ram_we or ram_oe is 1, latching bus_addr and bus_wdata at acceptance.
REQ-015 SHALL pulse bus_err for one cycle, with no SRAM access, when ram_cs=1, ram_we=1 and ram_oe=1 together.
REQ-016 SHALL pulse bus_err for one cycle, with no SRAM access, when bus_addr[2:0]!=0 or bus_addr[63:MEM_AW+2]!=0.
REQ-017 SHALL split each 64-bit access into two word beats: a low word at mem_addr={bus_addr[MEM_AW+1:3],0} carrying data[31:0], then a high word at mem_addr={bus_addr[MEM_AW+1:3],1} carrying data[63:32].
REQ-018 SHALL use states IDLE, RD_LO, RD_HI, RD_CAP, WR_LO, WR_HI, DONE, HOLD.
REQ-019 SHALL follow the read path IDLE->RD_LO->RD_HI->RD_CAP->DONE:
- RD_LO issues the low read.
- RD_HI issues the high read and captures the low word.
- RD_CAP captures the high word.
REQ-020 SHALL follow the write path IDLE->WR_LO->WR_HI->DONE, asserting mem_en=1 and mem_we=1 in both beats.
REQ-021 SHALL, in DONE, assert bus_ready=1 for exactly one cycle and present the assembled 64-bit word on bus_rdata for reads.
REQ-022 SHALL give latency from acceptance edge to bus_ready of 4 cycles for reads and 3 cycles for writes.
REQ-023 SHALL, after DONE or after an error pulse, wait in HOLD until ram_cs=0 before returning to IDLE, so a held strobe never retriggers.
REQ-024 SHALL ignore strobe changes during RD_*/WR_* states; the latched address and data are used.
REQ-025 SHALL hold bus_rdata stable between completions; it updates only in DONE of a read.
REQ-026 SHALL keep mem_en=0 and mem_we=0 in IDLE, DONE and HOLD.

Reset
REQ-027 SHALL, on reset=0, immediately and asynchronously force state IDLE and drive bus_ready, bus_err, mem_en, mem_we, mem_addr, mem_wdata and bus_rdata to 0.
REQ-028 SHALL abort an in-flight access on reset mid-operation, leaving at most one word beat written; no bus_ready is issued.
REQ-029 SHALL resume acceptance on the first rising clk after reset returns to 1.

Structure
REQ-030 SHALL define the state enumeration and the MEM_AW default in the shared package ram_bridge_pkg.
REQ-031 SHALL be implemented as a single module; no sub-module is needed, and the bench uses a behavioural one-cycle-latency SRAM model sram_sync.

Verification
REQ-032 SHALL cover a read: SRAM words 4,5 = 0x11223344, 0xAABBCCDD; read at bus_addr=0x10 -> bus_ready 4 cycles later with bus_rdata=0xAABBCCDD11223344.
REQ-033 SHALL cover a write: bus_addr=0x18, bus_wdata=0x0123456789ABCDEF -> word 6=0x89ABCDEF, word 7=0x01234567, bus_ready 3 cycles later.
REQ-034 SHALL cover errors: bus_addr=0x14, then ram_we=ram_oe=1, then bus_addr=0x40000 -> one bus_err pulse each, mem_en never asserted.
REQ-035 SHALL cover a held strobe: keep ram_cs=1, ram_oe=1 for 10 cycles after bus_ready -> exactly one access and one bus_ready.
REQ-036 SHALL cover reset mid-access: assert reset in WR_HI -> all outputs 0 asynchronously; word 7 unchanged; next read completes normally.
